// File: rtl/uart_rx_fifo_cti.sv
// UART receive buffer: circular FIFO of {err, data} with RDA, character-timeout (CTI) and overrun sources.
// Define UART_RX_FIFO_WATERMARK_EN to add the peak fill-level register (peak_o / peak_clr_i).
module uart_rx_fifo_cti #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int CTI_CHARS  = 4
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [DIV_WIDTH-1:0]          cfg_div_i,
    input  logic [1:0]                    cfg_bits_i,
    input  logic                          cfg_parity_en_i,
    input  logic [1:0]                    cfg_trigger_i,
    input  logic                          clr_i,
    input  logic [DATA_WIDTH-1:0]         rx_data_i,
    input  logic                          rx_err_i,
    input  logic                          rx_valid_i,
    input  logic                          pop_i,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic                          err_o,
    output logic                          valid_o,
    output logic [$clog2(FIFO_DEPTH):0]   elements_o,
    output logic                          rda_o,
    output logic                          cti_o,
    output logic                          overrun_o,
`ifdef UART_RX_FIFO_WATERMARK_EN
    output logic [$clog2(FIFO_DEPTH):0]   peak_o,
    input  logic                          peak_clr_i,
`endif
    input  logic                          overrun_clr_i
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CTI_CHARS * 11 + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_FIRED = 2'd2
    } cti_state_e;

    logic [DATA_WIDTH:0]  mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH:0]  head_s;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d, trig_lvl_s;
    logic                 rda_q, rda_d, overrun_q, overrun_d;
    logic                 empty_s, full_s, push_ok_s, pop_ok_s, overrun_ev_s;

    cti_state_e           state_q;
    logic [DIV_WIDTH-1:0] presc_q, div_eff_s;
    logic [BW-1:0]        bits_q, bit_nxt_s, target_s;
    logic                 tick_s, cti_q;

    // Pointer/count next state; clr_i overrides push and pop
    always_comb begin
        empty_s      = (count_q == CW'(0));
        full_s       = (count_q == CW'(FIFO_DEPTH));
        pop_ok_s     = pop_i && !empty_s && !clr_i;
        push_ok_s    = rx_valid_i && (!full_s || pop_i) && !clr_i;
        overrun_ev_s = rx_valid_i && full_s && !pop_i && !clr_i;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        if (clr_i) begin
            wr_ptr_d = AW'(0);
            rd_ptr_d = AW'(0);
            count_d  = CW'(0);
        end else begin
            wr_ptr_d = push_ok_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_d = pop_ok_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
            count_d  = count_q + CW'(push_ok_s) - CW'(pop_ok_s);
        end
    end

    // Trigger level decode, RDA compare and sticky overrun next state
    always_comb begin
        case (cfg_trigger_i)
            2'b00:   trig_lvl_s = CW'(1);
            2'b01:   trig_lvl_s = CW'(FIFO_DEPTH / 4);
            2'b10:   trig_lvl_s = CW'(FIFO_DEPTH / 2);
            2'b11:   trig_lvl_s = CW'(FIFO_DEPTH - 2);
            default: trig_lvl_s = CW'(1);
        endcase
        rda_d = (count_d >= trig_lvl_s);
        if (overrun_ev_s) begin
            overrun_d = 1'b1;
        end else if (overrun_clr_i) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // FIFO control registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q  <= AW'(0);
            rd_ptr_q  <= AW'(0);
            count_q   <= CW'(0);
            rda_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rda_q     <= rda_d;
            overrun_q <= overrun_d;
        end
    end

    // Entry storage, deliberately not reset; outputs are masked while empty
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= {rx_err_i, rx_data_i};
        end
    end

    // Bit-time prescaler and idle character-time target (char_bits = 7 + bits + parity)
    always_comb begin
        div_eff_s = (cfg_div_i == DIV_WIDTH'(0)) ? DIV_WIDTH'(1) : cfg_div_i;
        tick_s    = (presc_q >= div_eff_s - DIV_WIDTH'(1));
        bit_nxt_s = bits_q + BW'(tick_s);
        target_s  = BW'(CTI_CHARS) * (BW'(7) + BW'(cfg_bits_i) + BW'(cfg_parity_en_i));
    end

    // Character-timeout FSM; firing on the next bit count makes cti_o rise on the target tick itself
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            presc_q <= DIV_WIDTH'(0);
            bits_q  <= BW'(0);
            cti_q   <= 1'b0;
        end else if (clr_i || count_d == CW'(0)) begin
            state_q <= ST_IDLE;
            presc_q <= DIV_WIDTH'(0);
            bits_q  <= BW'(0);
            cti_q   <= 1'b0;
        end else if (rx_valid_i || pop_ok_s) begin
            state_q <= ST_COUNT;
            presc_q <= DIV_WIDTH'(0);
            bits_q  <= BW'(0);
            cti_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_COUNT;
                    presc_q <= DIV_WIDTH'(0);
                    bits_q  <= BW'(0);
                    cti_q   <= 1'b0;
                end
                ST_COUNT: begin
                    presc_q <= tick_s ? DIV_WIDTH'(0) : presc_q + DIV_WIDTH'(1);
                    bits_q  <= bit_nxt_s;
                    if (bit_nxt_s >= target_s) begin
                        state_q <= ST_FIRED;
                        cti_q   <= 1'b1;
                    end else begin
                        state_q <= ST_COUNT;
                        cti_q   <= 1'b0;
                    end
                end
                ST_FIRED: begin
                    state_q <= ST_FIRED;
                    cti_q   <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    presc_q <= DIV_WIDTH'(0);
                    bits_q  <= BW'(0);
                    cti_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_RX_FIFO_WATERMARK_EN
    logic [CW-1:0] peak_q;

    // Peak fill level; a clear loads the post-update count
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            peak_q <= CW'(0);
        end else if (peak_clr_i || count_d > peak_q) begin
            peak_q <= count_d;
        end else begin
            peak_q <= peak_q;
        end
    end

    assign peak_o = peak_q;
`endif

    assign head_s     = mem_q[rd_ptr_q];
    assign data_o     = empty_s ? DATA_WIDTH'(0) : head_s[DATA_WIDTH-1:0];
    assign err_o      = empty_s ? 1'b0 : head_s[DATA_WIDTH];
    assign valid_o    = !empty_s;
    assign elements_o = count_q;
    assign rda_o      = rda_q;
    assign cti_o      = cti_q;
    assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo_cti.sv
// Scoreboard bench for uart_rx_fifo_cti: DEPTH=16, div=4, 8-bit characters, parity off.
module tb_uart_rx_fifo_cti;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int DIVW  = 16;
    localparam int CW    = 5;

    logic            clk_i = 1'b0;
    logic            rstn_i;
    logic [DIVW-1:0] cfg_div_i;
    logic [1:0]      cfg_bits_i;
    logic            cfg_parity_en_i;
    logic [1:0]      cfg_trigger_i;
    logic            clr_i;
    logic [DW-1:0]   rx_data_i;
    logic            rx_err_i;
    logic            rx_valid_i;
    logic            pop_i;
    logic [DW-1:0]   data_o;
    logic            err_o;
    logic            valid_o;
    logic [CW-1:0]   elements_o;
    logic            rda_o;
    logic            cti_o;
    logic            overrun_o;
    logic            overrun_clr_i;
`ifdef UART_RX_FIFO_WATERMARK_EN
    logic [CW-1:0]   peak_o;
    logic            peak_clr_i;
`endif

    logic [DW:0] sb_q[$];
    int n_vec = 0;
    int n_mis = 0;
    int cyc;

    uart_rx_fifo_cti #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DIVW), .CTI_CHARS(4)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .cfg_div_i(cfg_div_i), .cfg_bits_i(cfg_bits_i),
        .cfg_parity_en_i(cfg_parity_en_i), .cfg_trigger_i(cfg_trigger_i), .clr_i(clr_i),
        .rx_data_i(rx_data_i), .rx_err_i(rx_err_i), .rx_valid_i(rx_valid_i), .pop_i(pop_i),
        .data_o(data_o), .err_o(err_o), .valid_o(valid_o), .elements_o(elements_o),
        .rda_o(rda_o), .cti_o(cti_o), .overrun_o(overrun_o),
`ifdef UART_RX_FIFO_WATERMARK_EN
        .peak_o(peak_o), .peak_clr_i(peak_clr_i),
`endif
        .overrun_clr_i(overrun_clr_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic e);
        rx_data_i  = d;
        rx_err_i   = e;
        rx_valid_i = 1'b1;
        if (sb_q.size() < DEPTH) sb_q.push_back({e, d});
        step();
        rx_valid_i = 1'b0;
    endtask

    task automatic pop_chk(input string tag);
        logic [DW:0] exp_e;
        if (sb_q.size() == 0) begin
            chk({tag, "_valid"}, 32'(valid_o), 32'(0));
        end else begin
            exp_e = sb_q.pop_front();
            chk({tag, "_data"}, 32'(data_o), 32'(exp_e[DW-1:0]));
            chk({tag, "_err"}, 32'(err_o), 32'(exp_e[DW]));
        end
        pop_i = 1'b1;
        step();
        pop_i = 1'b0;
    endtask

    task automatic flush();
        clr_i = 1'b1;
        sb_q.delete();
        step();
        clr_i = 1'b0;
    endtask

    task automatic wait_cti(input int limit, output int n);
        n = 0;
        while (cti_o !== 1'b1 && n < limit) begin
            step();
            n++;
        end
    endtask

    initial begin
        logic [DW:0] head_e;
        rstn_i = 1'b0; cfg_div_i = 16'd4; cfg_bits_i = 2'd3; cfg_parity_en_i = 1'b0;
        cfg_trigger_i = 2'b00; clr_i = 1'b0; rx_data_i = 8'h00; rx_err_i = 1'b0;
        rx_valid_i = 1'b0; pop_i = 1'b0; overrun_clr_i = 1'b0;
`ifdef UART_RX_FIFO_WATERMARK_EN
        peak_clr_i = 1'b0;
`endif
        repeat (3) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        step();

        chk("rst_valid", 32'(valid_o), 32'(0));
        chk("rst_elems", 32'(elements_o), 32'(0));
        chk("rst_data", 32'(data_o), 32'(0));
        chk("rst_err", 32'(err_o), 32'(0));
        chk("rst_rda", 32'(rda_o), 32'(0));
        chk("rst_cti", 32'(cti_o), 32'(0));
        chk("rst_ovr", 32'(overrun_o), 32'(0));

        // basic push/pop ordering
        push(8'hA5, 1'b0);
        push(8'h3C, 1'b1);
        chk("basic_elems2", 32'(elements_o), 32'(2));
        pop_chk("basic0");
        pop_chk("basic1");
        chk("basic_valid0", 32'(valid_o), 32'(0));
        chk("basic_elems0", 32'(elements_o), 32'(0));

        // pop on empty must not move the read pointer
        pop_i = 1'b1;
        step();
        pop_i = 1'b0;
        chk("popempty_elems", 32'(elements_o), 32'(0));
        push(8'h5A, 1'b1);
        pop_chk("popempty");

        // overflow: 17th character dropped
        for (int i = 0; i < 16; i++) push(8'(i * 7 + 1), i[0]);
        push(8'hEE, 1'b0);
        chk("ovf_flag", 32'(overrun_o), 32'(1));
        chk("ovf_elems", 32'(elements_o), 32'(16));
        head_e = sb_q[0];
        chk("ovf_head", 32'(data_o), 32'(head_e[DW-1:0]));
        overrun_clr_i = 1'b1;
        step();
        overrun_clr_i = 1'b0;
        chk("ovf_clr", 32'(overrun_o), 32'(0));

        // push + pop when full
        head_e = sb_q.pop_front();
        chk("full_pp_head", 32'(data_o), 32'(head_e[DW-1:0]));
        rx_data_i = 8'h77; rx_err_i = 1'b1; rx_valid_i = 1'b1; pop_i = 1'b1;
        sb_q.push_back({1'b1, 8'h77});
        step();
        rx_valid_i = 1'b0; pop_i = 1'b0;
        chk("full_pp_elems", 32'(elements_o), 32'(16));
        chk("full_pp_ovr", 32'(overrun_o), 32'(0));
        for (int i = 0; i < 16; i++) pop_chk("drain");
        chk("drain_valid", 32'(valid_o), 32'(0));

        // overrun set and clear in the same cycle; clr_i leaves overrun alone
        for (int i = 0; i < 16; i++) push(8'(i + 8'h40), 1'b0);
        rx_data_i = 8'hDD; rx_valid_i = 1'b1; overrun_clr_i = 1'b1;
        step();
        rx_valid_i = 1'b0; overrun_clr_i = 1'b0;
        chk("ovr_setclr", 32'(overrun_o), 32'(1));
        flush();
        chk("clr_keep_ovr", 32'(overrun_o), 32'(1));
        chk("clr_elems", 32'(elements_o), 32'(0));
        overrun_clr_i = 1'b1;
        step();
        overrun_clr_i = 1'b0;
        chk("ovr_clr2", 32'(overrun_o), 32'(0));

        // RDA at trigger DEPTH/2
        cfg_trigger_i = 2'b10;
        for (int i = 0; i < 7; i++) push(8'(i + 8'h10), 1'b0);
        chk("rda_7", 32'(rda_o), 32'(0));
        push(8'h17, 1'b0);
        chk("rda_8", 32'(rda_o), 32'(1));
        pop_chk("rda_pop");
        chk("rda_after_pop", 32'(rda_o), 32'(0));
        flush();
        cfg_trigger_i = 2'b00;

        // character timeout: 4 chars x 10 bits x 4 clocks
        push(8'h11, 1'b0);
        wait_cti(400, cyc);
        chk("cti_lat", 32'(cyc), 32'(160));
        pop_chk("cti_pop");
        chk("cti_pop_clr", 32'(cti_o), 32'(0));
        push(8'h22, 1'b0);
        repeat (99) step();
        chk("cti_early", 32'(cti_o), 32'(0));
        push(8'h33, 1'b0);
        wait_cti(400, cyc);
        chk("cti_restart", 32'(cyc), 32'(160));
        pop_chk("cti_pop2");
        chk("cti_pop2_clr", 32'(cti_o), 32'(0));
        flush();

        // clr_i with a simultaneous push, 5 entries, CTI pending
        for (int i = 0; i < 4; i++) push(8'(i + 8'h60), 1'b0);
`ifdef UART_RX_FIFO_WATERMARK_EN
        peak_clr_i = 1'b1;
`endif
        push(8'h64, 1'b0);
`ifdef UART_RX_FIFO_WATERMARK_EN
        peak_clr_i = 1'b0;
        chk("peak_clr_push", 32'(peak_o), 32'(5));
`endif
        wait_cti(400, cyc);
        chk("cti5_lat", 32'(cyc), 32'(160));
        clr_i = 1'b1; rx_valid_i = 1'b1; rx_data_i = 8'h99;
        sb_q.delete();
        step();
        clr_i = 1'b0; rx_valid_i = 1'b0;
        chk("clrpush_elems", 32'(elements_o), 32'(0));
        chk("clrpush_valid", 32'(valid_o), 32'(0));
        chk("clrpush_cti", 32'(cti_o), 32'(0));
        chk("clrpush_ovr", 32'(overrun_o), 32'(0));
`ifdef UART_RX_FIFO_WATERMARK_EN
        chk("clrpush_peak", 32'(peak_o), 32'(5));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo_cti.md
Name: uart_rx_fifo_cti

Overview:
Parametrised UART receive buffer for the next-generation APB UART. It sits between the uart_rx shift engine and the APB register file.
- Stores received characters together with their error flags.
- Generates 16550-style interrupt sources: RDA (received data available), CTI (character timeout) and overrun.
- Generalises the current fixed-depth RX path: programmable depth and width, a working character timeout instead of a tied-off one, and overrun detection.

Parameters:
DATA_WIDTH, 8, character width stored per entry.
FIFO_DEPTH, 16, entries; power of two, >= 4.
DIV_WIDTH, 16, width of the baud divisor.
CTI_CHARS, 4, number of idle character times before CTI asserts.

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
cfg_div_i  in  DIV_WIDTH  clock cycles per bit; 0 treated as 1
cfg_bits_i  in  2  character length = 5 + cfg_bits_i
cfg_parity_en_i  in  1  parity bit present (affects character time only)
cfg_trigger_i  in  2  RDA trigger: 00 -> 1, 01 -> DEPTH/4, 10 -> DEPTH/2, 11 -> DEPTH-2
clr_i  in  1  synchronous flush
rx_data_i  in  DATA_WIDTH  character from the shift engine
rx_err_i  in  1  parity/framing error of rx_data_i
rx_valid_i  in  1  single-cycle push strobe; no backpressure
pop_i  in  1  consume head entry
data_o  out  DATA_WIDTH  head entry data
err_o  out  1  head entry error flag
valid_o  out  1  FIFO non-empty
elements_o  out  $clog2(FIFO_DEPTH)+1  fill level
rda_o  out  1  elements_o >= trigger level
cti_o  out  1  character timeout pending
overrun_o  out  1  sticky overrun flag
overrun_clr_i  in  1  clears overrun_o

Behaviour:
- Reset: pointers and count 0; valid_o, rda_o, cti_o and overrun_o = 0; elements_o = 0; data_o and err_o = 0 (storage is not reset, but outputs are masked while empty).
- Storage: circular buffer of {err, data}, with read/write pointers wrapping modulo FIFO_DEPTH and a separate count register.
- Latency: a push in cycle N is visible on valid_o, data_o and elements_o in N+1. data_o shows the head combinationally from storage.
- Push, not full: write the entry; count +1.
- Push, full, no pop: character dropped; overrun_o set next cycle; count unchanged.
- Push and pop together when full: both performed; count unchanged; no overrun.
- Push and pop together when non-empty and not full: both performed; count unchanged.
- Pop when empty: ignored; no pointer movement.
- clr_i has priority over push and pop in the same cycle: pointers and count go to 0, cti_o clears, a simultaneous push is discarded without overrun, and overrun_o is not affected.
- overrun_clr_i and an overrun event in the same cycle: overrun_o stays set.
- rda_o: registered compare of the next count against the trigger level; updates with elements_o.
- Character time in bits: char_bits = 1 start + (5 + cfg_bits_i) + cfg_parity_en_i + 1 stop, giving a range of 7..11.
- Timeout machine, states IDLE, COUNT, FIRED:
  - Prescaler counts 0..max(cfg_div_i,1)-1 and emits one bit tick per wrap.
  - Bit counter width is sized for CTI_CHARS*11.
  - IDLE -> COUNT when the FIFO is non-empty; both counters start at 0.
  - Any push, pop or clr_i zeroes both counters; an empty FIFO forces IDLE.
  - COUNT -> FIRED when the bit counter reaches CTI_CHARS*char_bits; cti_o = 1 while in FIRED.
  - FIRED -> COUNT on push or pop with the FIFO still non-empty; FIRED -> IDLE on clr_i or when the FIFO becomes empty.
  - A cfg change mid-count takes effect on the next compare; counters are not restarted.
- Reset asserted mid-operation clears everything asynchronously; no partial entries survive.

Optional Feature:
UART_RX_FIFO_WATERMARK_EN:
- Defined: adds ports peak_o (width as elements_o) and peak_clr_i.
  - peak_o is a register holding the maximum elements_o value since reset or since peak_clr_i.
  - On peak_clr_i, peak_o loads the current count.
  - peak_clr_i together with a push loads the post-push count.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- All scenarios: DEPTH=16, div=4, cfg_bits=3, parity off.
- Push 0xA5, 0x3C, then pop twice -> data_o 0xA5 then 0x3C, valid_o drops after the second pop, elements_o 2 -> 0.
- Push 17 characters without popping -> elements_o = 16, overrun_o = 1 the cycle after the 17th push, head still the first character. overrun_clr_i -> overrun_o = 0.
- Fill to 16, then push+pop in one cycle -> elements_o stays 16, overrun_o stays 0, the new entry lands at the tail.
- cfg_trigger=10, push 7 -> rda_o = 0; 8th push -> rda_o = 1 next cycle; one pop -> rda_o = 0.
- Push one character, then idle -> cti_o rises exactly 160 cycles after the push (4 chars x 10 bits x 4 clocks). A pop then deasserts it next cycle. Pushing at cycle 100 restarts the count.
- clr_i in the same cycle as rx_valid_i with 5 entries -> elements_o = 0, valid_o = 0, cti_o = 0, overrun_o unchanged. With UART_RX_FIFO_WATERMARK_EN defined, peak_o = 5 afterwards.
